// File: rtl/obi_mem_responder_if.sv
// Request/grant/response bus between an initiator and the memory responder.
interface obi_mem_responder_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_mem_responder.sv
// Word-addressed SRAM responder with a programmable grant wait, fixed one-cycle
// response latency and error responses for out-of-range or misaligned accesses.
module obi_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h00100000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned GNT_WAIT  = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  obi_mem_responder_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam logic [32:0] AddrLo  = {1'b0, BASE_ADDR};
  localparam logic [32:0] AddrHi  = AddrLo + (33'(DEPTH) << 2);
  localparam logic [3:0]  WaitCnt = 4'(GNT_WAIT);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            rvalid_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic            gnt;
  logic            addr_ok;
  logic            wr_en;
  logic [31:0]     offset;
  logic [IdxW-1:0] idx;

  always_comb begin
    offset  = bus.addr - BASE_ADDR;
    idx     = IdxW'(offset >> 2);
    // 33-bit compare so the upper bound cannot wrap near the top of the map.
    addr_ok = ({1'b0, bus.addr} >= AddrLo) && ({1'b0, bus.addr} < AddrHi) &&
              (bus.addr[1:0] == 2'b00);
    // Gated by reset so nothing is granted, and nothing written, while held in reset.
    gnt     = rst_ni && bus.req && (cnt_q == WaitCnt);
    wr_en   = gnt && bus.we && addr_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      if (gnt) begin
        err_q   <= !addr_ok;
        rdata_q <= (addr_ok && !bus.we) ? mem[idx] : '0;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.req && !gnt) begin
            state_q <= StStall;
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        StStall: begin
          // Dropping req abandons the request; a grant restarts the count.
          if (!bus.req || gnt) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.be[k]) begin
          mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
        end
      end
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/rvalid instruction/data bus: the far end of the path that the core-side decoders forward onto.
- Backs a word-addressed SRAM array mapped at BASE_ADDR.
- Has a configurable grant wait state, a one-cycle response latency, and error signalling for out-of-range or misaligned accesses.
- Used as the main instruction/data memory model in SoC simulation, and as a synthesizable on-chip RAM.

Parameters:
- BASE_ADDR, 32'h00100000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words. Must be a power of two, >= 2.
- GNT_WAIT, 0, cycles req_i must be held before gnt_o asserts. Range 0..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request from initiator.
- gnt_o  out  1  grant; request accepted this cycle.
- rvalid_o  out  1  response valid.
- addr_i  in  32  byte address; held stable while req_i is high and not yet granted.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, valid when rvalid_o is high.
- err_o  out  1  error flag, valid when rvalid_o is high.

Behaviour:
- Reset (rst_ni low, async): gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0, FSM=IDLE.
  - A pending response is discarded; no rvalid after reset release.
  - Array contents are not reset.
- FSM states:
  - IDLE: no request pending.
  - STALL: request pending, counting wait cycles.
- Transitions:
  - IDLE -> STALL when req_i=1 and GNT_WAIT>0.
  - STALL -> IDLE on grant, or when req_i drops.
  - When req_i drops in STALL, the counter clears; the transaction is abandoned with no side effect.
- Grant:
  - gnt_o is combinational: gnt_o = req_i and (counter == GNT_WAIT).
  - With GNT_WAIT=0, gnt_o follows req_i in the same cycle, and back-to-back grants occur every cycle.
  - The counter increments each cycle in STALL without a grant, and clears to 0 on grant.
  - After a grant, a still-high req_i is a new request and starts a fresh count.
- Address check:
  - Valid iff addr_i >= BASE_ADDR, addr_i < BASE_ADDR + 4*DEPTH, and addr_i[1:0] == 0.
  - Compare using 33-bit arithmetic so BASE_ADDR + 4*DEPTH cannot wrap.
  - Word index = (addr_i - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- Transaction at the granted clock edge:
  - Valid write: each byte lane with be_i[k]=1 is written from wdata_i; other lanes are unchanged.
  - Valid read: rdata register <= array[index].
  - Invalid access: no array write; rdata register <= 0; err register <= 1.
  - Valid write: rdata register <= 0; err register <= 0.
- Response:
  - rvalid_o=1 exactly one cycle after each grant, for one cycle per grant; otherwise 0.
  - rdata_o and err_o are held at their last values when rvalid_o=0.
  - Exactly one response per grant, in grant order. At most one response is in flight, because latency is fixed at 1.
- Read-after-write to the same word on consecutive grants: the read returns the newly written data, since the write commits at the first grant edge.
- Write with be_i=0: granted and responded with err_o=0, array unchanged.
- Simultaneous reset assertion and grant: reset wins; no write occurs if reset is asserted before the edge.

Test Plan:
1. GNT_WAIT=0: write 32'hDEADBEEF, be=4'hF at 32'h00100010; then read the same address. Expect gnt in the same cycle as req, rvalid one cycle later, and read rdata=32'hDEADBEEF with err=0.
2. Byte enables: word at 32'h00100020 holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101; read back. Expect 32'h11BB33DD.
3. GNT_WAIT=3: hold req for a read. Expect gnt in the 4th cycle of req and rvalid in the 5th. Drop req after 2 cycles on a second request: expect no gnt and no rvalid.
4. Errors: read 32'h000FFFFC (below base), 32'h00101000 with DEPTH=1024 (one past end), and 32'h00100002 (misaligned). Each expects rvalid with err=1 and rdata=0. A write to an out-of-range address leaves the array unchanged.
5. Streaming with GNT_WAIT=0: req held for 4 cycles reading words 0..3 preloaded 1,2,3,4. Expect 4 consecutive gnts and 4 consecutive rvalids returning 1,2,3,4 in order.
6. Reset mid-operation: assert rst_ni=0 in the cycle after a grant. Expect rvalid_o, gnt_o, rdata_o and err_o all 0 immediately, no response after release, and array data written before reset still readable.
